npu_mac_engine: RTL and testbench

Parametrised multiply-accumulate core for the NPU that replaces the fixed three-lane, host-stepped conv/FCN datapath. It has NUM_PE signed MAC lanes and three modes: summed conv window, independent lanes, and broadcast-input FCN. A job runs autonomously over a programmable number of input beats. Results are requantised (arithmetic shift, optional ReLU, 8-bit saturation) and packed four bytes per 32-bit word behind a valid/ready output. It sits between the host register interface (input/weight staging) and the result readback path.

---
 rtl/npu_mac_engine.sv | 247 ++++++++++++++++++++++++
 tb/tb_npu_mac_engine.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mac_engine.sv
// npu_mac_engine: parametrised signed multiply-accumulate engine.
//
// The engine has NUM_PE lanes and three modes: summed conv window, independent
// lanes, and broadcast-input FCN. A job runs over cfg_len input beats. Each
// result is requantised, then packed four bytes per 32-bit output word.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_start              job start pulse (sampled only in IDLE)
//   cfg_len                beats in the job (0 allowed)
//   cfg_mode               0 SUM, 1 LANE, 2 BCAST, 3 treated as SUM
//   cfg_shift, cfg_relu    requantisation: arithmetic shift, optional ReLU
//   cfg_last               flush the packer when this job finishes
//   in_valid/in_ready      input beat handshake
//   in_act, in_wgt, in_neg lane activations (unsigned), weights (signed), negate flag
//   out_valid/out_ready    packed-word handshake
//   out_data, out_last     packed bytes (first result in [7:0]), final-word flag
//   busy, done             FSM not idle, one-cycle completion pulse
module npu_mac_engine #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [1:0]               cfg_mode,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     cfg_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_PE*DATA_W-1:0] in_act,
    input  logic [NUM_PE*DATA_W-1:0] in_wgt,
    input  logic                     in_neg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [1:0] MODE_SUM   = 2'd0;
    localparam logic [1:0] MODE_BCAST = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic [1:0]         mode_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic               last_q;
    logic [ACC_W-1:0]   acc [NUM_PE];
    logic [IDX_W-1:0]   drain_idx;
    logic [1:0]         pk_cnt;
    logic [31:0]        pk_word;

    // Lane products, each sign-extended to the accumulator width
    logic signed [DATA_W:0] act_c  [NUM_PE];
    logic [ACC_W-1:0]       prod_c [NUM_PE];
    logic [ACC_W-1:0]       sum_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (mode_q == MODE_BCAST) begin
                act_c[i] = $signed({1'b0, in_act[0 +: DATA_W]});
            end else begin
                act_c[i] = $signed({1'b0, in_act[i*DATA_W +: DATA_W]});
            end
            if (in_neg) begin
                act_c[i] = -act_c[i];
            end
            prod_c[i] = ACC_W'(act_c[i]) * ACC_W'($signed(in_wgt[i*DATA_W +: DATA_W]));
            sum_c     = sum_c + prod_c[i];
        end
    end

    // Requantise the accumulator currently selected for draining
    logic signed [ACC_W-1:0] shifted_c;
    logic signed [ACC_W-1:0] clamped_c;
    logic [7:0]              q_byte_c;

    always_comb begin
        shifted_c = $signed(acc[drain_idx]) >>> shift_q;
        clamped_c = shifted_c;
        if (relu_q && shifted_c[ACC_W-1]) begin
            clamped_c = '0;
        end
        if (clamped_c > SAT_MAX) begin
            clamped_c = SAT_MAX;
        end else if (clamped_c < SAT_MIN) begin
            clamped_c = SAT_MIN;
        end
        q_byte_c = clamped_c[7:0];
    end

    // Packer / output-register control. The fourth byte may only enter when the
    // output register is free (or being emptied this cycle), so DRAIN stalls there.
    logic             is_sum_c;
    logic [IDX_W-1:0] r_last_c;
    logic             out_free_c;
    logic             push_c;
    logic             flush_need_c;
    logic             flush_c;
    logic             load_c;
    logic [31:0]      pk_word_nxt_c;
    logic [31:0]      load_data_c;
    logic             load_last_c;

    always_comb begin
        is_sum_c      = (mode_q == MODE_SUM);
        r_last_c      = is_sum_c ? '0 : IDX_W'(NUM_PE - 1);
        out_free_c    = !out_valid || out_ready;
        push_c        = (state == ST_DRAIN) && ((pk_cnt != 2'd3) || out_free_c);
        flush_need_c  = (state == ST_DONE) && last_q && (pk_cnt != 2'd0);
        flush_c       = flush_need_c && out_free_c;
        pk_word_nxt_c = pk_word;
        pk_word_nxt_c[{pk_cnt, 3'b000} +: 8] = q_byte_c;
        load_c        = (push_c && (pk_cnt == 2'd3)) || flush_c;
        load_data_c   = flush_c ? pk_word : pk_word_nxt_c;
        load_last_c   = flush_c ? 1'b1 : (last_q && (drain_idx == r_last_c));
    end

    // FSM, accumulators, packer and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            mode_q    <= MODE_SUM;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            last_q    <= 1'b0;
            drain_idx <= '0;
            pk_cnt    <= '0;
            pk_word   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= load_data_c;
                out_last  <= load_last_c;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
            end

            // Unfilled byte slots are kept zero so a flush word is zero-padded
            if (push_c) begin
                if (pk_cnt == 2'd3) begin
                    pk_word <= '0;
                    pk_cnt  <= '0;
                end else begin
                    pk_word <= pk_word_nxt_c;
                    pk_cnt  <= pk_cnt + 2'd1;
                end
            end else if (flush_c) begin
                pk_word <= '0;
                pk_cnt  <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        len_q     <= cfg_len;
                        mode_q    <= (cfg_mode == 2'd3) ? MODE_SUM : cfg_mode;
                        shift_q   <= cfg_shift;
                        relu_q    <= cfg_relu;
                        last_q    <= cfg_last;
                        beat_cnt  <= '0;
                        drain_idx <= '0;
                        busy      <= 1'b1;
                        in_ready  <= (cfg_len != '0);
                        state     <= (cfg_len == '0) ? ST_DRAIN : ST_ACC;
                        for (int i = 0; i < NUM_PE; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_valid && in_ready) begin
                        if (is_sum_c) begin
                            acc[0] <= acc[0] + sum_c;
                        end else begin
                            for (int i = 0; i < NUM_PE; i++) begin
                                acc[i] <= acc[i] + prod_c[i];
                            end
                        end
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt + LEN_W'(1) == len_q) begin
                            in_ready <= 1'b0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (push_c) begin
                        if (drain_idx == r_last_c) begin
                            drain_idx <= '0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            drain_idx <= drain_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Hold here only while a flush word waits for output space
                    if (!(flush_need_c && !out_free_c)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_mac_engine.sv
// Testbench for npu_mac_engine: directed jobs plus randomised jobs, checked by a
// scoreboard fed from a behavioural model (plain integer arithmetic + byte queue).
module tb_npu_mac_engine;

    localparam int unsigned NUM_PE  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned MAX_LEN = 256;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int          MAXB    = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cfg_start;
    logic [LEN_W-1:0]         cfg_len;
    logic [1:0]               cfg_mode;
    logic [4:0]               cfg_shift;
    logic                     cfg_relu;
    logic                     cfg_last;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_PE*DATA_W-1:0] in_act;
    logic [NUM_PE*DATA_W-1:0] in_wgt;
    logic                     in_neg;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_data;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    always #5 clk = ~clk;

    npu_mac_engine #(
        .NUM_PE (NUM_PE),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_len  (cfg_len),
        .cfg_mode (cfg_mode),
        .cfg_shift(cfg_shift),
        .cfg_relu (cfg_relu),
        .cfg_last (cfg_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_act   (in_act),
        .in_wgt   (in_wgt),
        .in_neg   (in_neg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int rdy_mode    = 2;    // 0 random, 1 held low, 2 held high

    int b_act [MAXB][NUM_PE];
    int b_wgt [MAXB][NUM_PE];
    bit b_neg [MAXB];

    logic [31:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [7:0]  pk_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] requant(input int acc, input int sh, input bit relu);
        logic signed [ACC_W-1:0] w;
        int v;
        w = acc[ACC_W-1:0];
        v = int'(w) >>> sh;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    // Reference: exact integer sums, wrapped at requantisation; byte queue packer
    task automatic model_job(input int mode, input int len, input int sh, input bit relu, input bit last);
        int acc [NUM_PE];
        int a, r;
        bit lanes;
        logic [31:0] word;
        lanes = (mode == 1) || (mode == 2);
        for (int i = 0; i < NUM_PE; i++) acc[i] = 0;
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < NUM_PE; i++) begin
                a = (mode == 2) ? b_act[b][0] : b_act[b][i];
                if (b_neg[b]) a = -a;
                if (lanes) acc[i] += a * b_wgt[b][i];
                else       acc[0] += a * b_wgt[b][i];
            end
        end
        r = lanes ? NUM_PE : 1;
        for (int k = 0; k < r; k++) begin
            pk_q.push_back(requant(acc[k], sh, relu));
            if (pk_q.size() == 4) begin
                word = {pk_q[3], pk_q[2], pk_q[1], pk_q[0]};
                exp_data_q.push_back(word);
                exp_last_q.push_back(last && (k == r - 1));
                pk_q.delete();
            end
        end
        if (last && pk_q.size() > 0) begin
            word = '0;
            for (int i = 0; i < pk_q.size(); i++) word[i*8 +: 8] = pk_q[i];
            exp_data_q.push_back(word);
            exp_last_q.push_back(1'b1);
            pk_q.delete();
        end
    endtask

    task automatic gen_beats(input int len);
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < NUM_PE; i++) begin
                b_act[b][i] = int'($urandom_range(0, 255));
                b_wgt[b][i] = int'($urandom_range(0, 255)) - 128;
            end
            b_neg[b] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic send_beat(input int b);
        int n;
        for (int i = 0; i < NUM_PE; i++) begin
            in_act[i*DATA_W +: DATA_W] = DATA_W'(b_act[b][i]);
            in_wgt[i*DATA_W +: DATA_W] = DATA_W'(b_wgt[b][i]);
        end
        in_neg   = b_neg[b];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 2000) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain_exp();
        int n;
        n = 0;
        while (exp_data_q.size() > 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("exp_queue_empty", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        cfg_start = 1'b0;
        exp_data_q.delete();
        exp_last_q.delete();
        pk_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
    endtask

    // Runs at posedge+1 timing; abort_at >= 0 resets the DUT before that beat
    task automatic run_job(input int mode, input int len, input int sh, input bit relu,
                           input bit last, input bit wait_done, input int abort_at);
        int d0;
        wait_idle();
        model_job(mode, len, sh, relu, last);
        d0        = done_cnt;
        cfg_mode  = 2'(mode);
        cfg_len   = LEN_W'(len);
        cfg_shift = 5'(sh);
        cfg_relu  = relu;
        cfg_last  = last;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("in_ready_after_start", 32'(in_ready), 32'(len > 0));
        for (int b = 0; b < len; b++) begin
            if (b == abort_at) begin
                do_reset();
                return;
            end
            send_beat(b);
        end
        if (wait_done) begin
            wait_idle();
            check("done_pulses", 32'(done_cnt - d0), 32'd1);
        end
    endtask

    // Output readiness pattern
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every accepted word and checks words hold while stalled
    initial begin
        logic        hold_prev;
        logic [31:0] held_d;
        logic        held_l;
        logic [31:0] ed;
        logic        el;
        hold_prev = 1'b0;
        held_d    = '0;
        held_l    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (hold_prev) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", out_data, held_d);
                    check("hold_last", 32'(out_last), 32'(held_l));
                end
                if (out_valid && out_ready) begin
                    if (exp_data_q.size() == 0) begin
                        check("word_pending", 32'(exp_data_q.size()), 32'd1);
                    end else begin
                        ed = exp_data_q.pop_front();
                        el = exp_last_q.pop_front();
                        check("out_data", out_data, ed);
                        check("out_last", 32'(out_last), 32'(el));
                    end
                end
                hold_prev = out_valid && !out_ready;
                held_d    = out_data;
                held_l    = out_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode, len;
        rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_mode = '0; cfg_shift = '0;
        cfg_relu = 1'b0; cfg_last = 1'b0; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_neg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // SUM window, acts 1, wgts 1..4, three beats
        rdy_mode = 1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NUM_PE; i++) begin
                b_act[b][i] = 1;
                b_wgt[b][i] = i + 1;
            end
            b_neg[b] = 1'b0;
        end
        run_job(0, 3, 0, 1'b0, 1'b1, 1'b1, -1);
        check("sum_word", out_data, 32'h0000_001E);
        check("sum_last", 32'(out_last), 32'd1);
        rdy_mode = 2;
        drain_exp();

        // Same job, second beat negated
        rdy_mode = 1;
        b_neg[1] = 1'b1;
        run_job(0, 3, 0, 1'b0, 1'b1, 1'b1, -1);
        check("neg_word", out_data, 32'h0000_000A);
        rdy_mode = 2;
        drain_exp();

        // BCAST with shift and ReLU
        rdy_mode = 1;
        b_act[0][0] = 200; b_act[0][1] = 7; b_act[0][2] = 7; b_act[0][3] = 7;
        b_wgt[0][0] = 1;   b_wgt[0][1] = -1; b_wgt[0][2] = 2; b_wgt[0][3] = 0;
        b_neg[0] = 1'b0;
        run_job(2, 1, 1, 1'b1, 1'b0, 1'b1, -1);
        check("bcast_word", out_data, 32'h007F_0064);
        check("bcast_last", 32'(out_last), 32'd0);
        rdy_mode = 2;
        drain_exp();

        // Four SUM jobs packing 1,2,3,4 with the output stalled
        rdy_mode = 1;
        for (int j = 1; j <= 4; j++) begin
            for (int i = 0; i < NUM_PE; i++) begin
                b_act[0][i] = (i == 0) ? 1 : 0;
                b_wgt[0][i] = (i == 0) ? j : 0;
            end
            b_neg[0] = 1'b0;
            run_job(0, 1, 0, 1'b0, (j == 4), 1'b1, -1);
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pack4_word", out_data, 32'h0403_0201);
        check("pack4_last", 32'(out_last), 32'd1);
        rdy_mode = 2;
        drain_exp();

        // Back-to-back LANE jobs against a blocked output
        rdy_mode = 1;
        gen_beats(2);
        run_job(1, 2, 6, 1'b0, 1'b0, 1'b1, -1);
        gen_beats(2);
        run_job(1, 2, 5, 1'b1, 1'b0, 1'b0, -1);
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        rdy_mode = 2;
        wait_idle();
        drain_exp();

        // Reset in the middle of a job, then a zero-length flush job
        gen_beats(5);
        run_job(0, 5, 3, 1'b0, 1'b1, 1'b1, 2);
        rdy_mode = 1;
        run_job(0, 0, 0, 1'b0, 1'b1, 1'b1, -1);
        check("len0_valid", 32'(out_valid), 32'd1);
        check("len0_word", out_data, 32'h0000_0000);
        check("len0_last", 32'(out_last), 32'd1);
        rdy_mode = 2;
        drain_exp();

        // Random jobs with random output back-pressure
        rdy_mode = 0;
        for (int j = 0; j < 30; j++) begin
            mode = int'($urandom_range(0, 3));
            len  = (j == 7) ? 40 : int'($urandom_range(0, 10));
            gen_beats(len);
            run_job(mode, len, int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 1'b1, -1);
        end
        rdy_mode = 2;
        wait_idle();
        drain_exp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
